// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures retired writeback-stage instructions into a
// FIFO from the first retire until a halt instruction or the retire limit,
// then drains the queued entries and parks in DONE until reset.
module retire_trace_buffer #(
   parameter int unsigned     DEPTH      = 16,
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] HALT_INSTR = XLEN'(32'h0000000d),
   parameter int unsigned     MAX_RETIRE = 7000,
   parameter int unsigned     FULL_MODE  = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid,
   input  logic [XLEN-1:0] wb_pc,
   input  logic [XLEN-1:0] wb_instr,
   input  logic            wb_we,
   input  logic [4:0]      wb_waddr,
   input  logic [XLEN-1:0] wb_wdata,
   output logic            trace_stall,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
   output logic            out_we,
   output logic [4:0]      out_waddr,
   output logic [XLEN-1:0] out_wdata,
   output logic [31:0]     retire_cnt,
   output logic [15:0]     drop_cnt,
   output logic [1:0]      state,
   output logic            done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = 3 * XLEN + 6;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   state_e        state_q;
   logic          done_q;
   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   rd_ptr_q;
   logic [31:0]   retire_cnt_q;
   logic [31:0]   retire_cnt_d;
   logic [15:0]   drop_cnt_q;
   logic [EW-1:0] mem_q [DEPTH];

   logic [EW-1:0] head_s;
   logic          empty_s;
   logic          full_s;
   logic          pop_s;
   logic          stall_s;
   logic          retire_s;
   logic          accept_s;
   logic          push_s;
   logic          drop_s;
   logic          end_capture_s;

   // Occupancy from the wrap-bit pointer pair.
   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   // A pop frees a slot in the same cycle, so a full FIFO being drained never stalls.
   assign pop_s    = !empty_s && out_ready;
   assign stall_s  = (FULL_MODE == 32'd1) && full_s && !pop_s && (state_q == ST_CAPTURE);
   assign retire_s = wb_valid && (wb_instr != {XLEN{1'b0}}) && !stall_s;

   // Only IDLE and CAPTURE record retires; a full FIFO without a pop loses the entry.
   assign accept_s = retire_s && ((state_q == ST_IDLE) || (state_q == ST_CAPTURE));
   assign push_s   = accept_s && (!full_s || pop_s);
   assign drop_s   = accept_s && full_s && !pop_s;

   assign retire_cnt_d  = retire_cnt_q + {31'd0, accept_s};
   assign end_capture_s = (wb_instr == HALT_INSTR) ||
                          ((MAX_RETIRE != 32'd0) && (retire_cnt_d == 32'(MAX_RETIRE)));

   assign head_s      = mem_q[rd_ptr_q[AW-1:0]];
   assign out_pc      = head_s[3*XLEN+5 -: XLEN];
   assign out_instr   = head_s[2*XLEN+5 -: XLEN];
   assign out_we      = head_s[XLEN+5];
   assign out_waddr   = head_s[XLEN+4 -: 5];
   assign out_wdata   = head_s[XLEN-1:0];
   assign out_valid   = !empty_s;
   assign trace_stall = stall_s;
   assign retire_cnt  = retire_cnt_q;
   assign drop_cnt    = drop_cnt_q;
   assign state       = state_q;
   assign done        = done_q;

   // Entry storage; contents are meaningless while out_valid is low, so it has no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {wb_pc, wb_instr, wb_we, wb_waddr, wb_wdata};
      end
   end

   // Capture FSM, FIFO pointers and the retire/drop counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         done_q       <= 1'b0;
         wr_ptr_q     <= {(AW+1){1'b0}};
         rd_ptr_q     <= {(AW+1){1'b0}};
         retire_cnt_q <= 32'd0;
         drop_cnt_q   <= 16'd0;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         retire_cnt_q <= retire_cnt_d;
         if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
         case (state_q)
            // A halt or limit on the very first retire skips straight to draining.
            ST_IDLE, ST_CAPTURE: begin
               if (accept_s) begin
                  state_q <= end_capture_s ? ST_DRAIN : ST_CAPTURE;
               end
            end
            ST_DRAIN: begin
               if (empty_s) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_DONE;
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: two instances share stimulus
// (index 0: DEPTH=4 drop-on-full MAX_RETIRE=10, index 1: DEPTH=4 backpressure,
// no limit) and are compared against a queue-style reference model.
module tb_retire_trace_buffer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic [31:0] wb_instr;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        out_ready;

   logic        d_stall [2];
   logic        d_ov    [2];
   logic [31:0] d_pc    [2];
   logic [31:0] d_instr [2];
   logic        d_we    [2];
   logic [4:0]  d_waddr [2];
   logic [31:0] d_wdata [2];
   logic [31:0] d_rc    [2];
   logic [15:0] d_dc    [2];
   logic [1:0]  d_state [2];
   logic        d_done  [2];

   // reference model: FIFO as an ordered list, entry 0 is the head
   ent_t        mf   [2][4];
   int          mcnt [2];
   int          mst  [2];
   int          mdc  [2];
   logic [31:0] mrc  [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   retire_trace_buffer #(.DEPTH(4), .XLEN(32), .HALT_INSTR(32'h0000000d),
                         .MAX_RETIRE(10), .FULL_MODE(0)) dut_a (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .trace_stall(d_stall[0]),
      .out_valid(d_ov[0]), .out_ready(out_ready), .out_pc(d_pc[0]), .out_instr(d_instr[0]),
      .out_we(d_we[0]), .out_waddr(d_waddr[0]), .out_wdata(d_wdata[0]),
      .retire_cnt(d_rc[0]), .drop_cnt(d_dc[0]), .state(d_state[0]), .done(d_done[0]));

   retire_trace_buffer #(.DEPTH(4), .XLEN(32), .HALT_INSTR(32'h0000000d),
                         .MAX_RETIRE(0), .FULL_MODE(1)) dut_b (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .trace_stall(d_stall[1]),
      .out_valid(d_ov[1]), .out_ready(out_ready), .out_pc(d_pc[1]), .out_instr(d_instr[1]),
      .out_we(d_we[1]), .out_waddr(d_waddr[1]), .out_wdata(d_wdata[1]),
      .retire_cnt(d_rc[1]), .drop_cnt(d_dc[1]), .state(d_state[1]), .done(d_done[1]));

   function automatic logic [31:0] mmax(int m);
      return (m == 0) ? 32'd10 : 32'd0;
   endfunction

   function automatic bit mstall(int m);
      return (m == 1) && (mcnt[m] == 4) && (out_ready == 1'b0) && (mst[m] == 1);
   endfunction

   function automatic ent_t dhead(int m);
      return {d_pc[m], d_instr[m], d_we[m], d_waddr[m], d_wdata[m]};
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mcnt[m] = 0;
         mst[m]  = 0;
         mdc[m]  = 0;
         mrc[m]  = 32'd0;
      end
   endtask

   // what one rising edge does to instance m, given the inputs now applied
   task automatic model_edge(int m);
      bit   pop;
      bit   full;
      bit   ret;
      int   ns;
      ent_t e;
      pop  = (mcnt[m] > 0) && (out_ready == 1'b1);
      full = (mcnt[m] == 4);
      ret  = (wb_valid == 1'b1) && (wb_instr != 32'd0) && !mstall(m) && (mst[m] <= 1);
      e    = {wb_pc, wb_instr, wb_we, wb_waddr, wb_wdata};
      ns   = mst[m];
      if (mst[m] == 2 && mcnt[m] == 0) ns = 3;
      if (pop) begin
         for (int i = 0; i < 3; i++) mf[m][i] = mf[m][i+1];
         mcnt[m] = mcnt[m] - 1;
      end
      if (ret) begin
         mrc[m] = mrc[m] + 32'd1;
         if (!full || pop) begin
            mf[m][mcnt[m]] = e;
            mcnt[m] = mcnt[m] + 1;
         end else if (mdc[m] < 65535) begin
            mdc[m] = mdc[m] + 1;
         end
         ns = (wb_instr == 32'h0000000d || (mmax(m) != 32'd0 && mrc[m] == mmax(m))) ? 2 : 1;
      end
      mst[m] = ns;
   endtask

   task automatic step();
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, logic [31:0] pc, logic [31:0] instr);
      wb_valid = v;
      wb_pc    = pc;
      wb_instr = instr;
      wb_we    = 1'($urandom_range(0, 1));
      wb_waddr = 5'($urandom_range(0, 31));
      wb_wdata = $urandom;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      idle_inputs();
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int m = 0; m < 2; m++) begin
         total++; if (d_state[m] !== 2'd0) begin bad++; $display("FAIL reset_state m=%0d got=%0d exp=0", m, d_state[m]); end
         total++; if (d_ov[m] !== 1'b0) begin bad++; $display("FAIL reset_ov m=%0d got=%b exp=0", m, d_ov[m]); end
         total++; if (d_rc[m] !== 32'd0 || d_dc[m] !== 16'd0) begin bad++; $display("FAIL reset_cnt m=%0d got=%0d/%0d exp=0/0", m, d_rc[m], d_dc[m]); end
         total++; if (d_done[m] !== 1'b0 || d_stall[m] !== 1'b0) begin bad++; $display("FAIL reset_flags m=%0d got=%b%b exp=00", m, d_done[m], d_stall[m]); end
      end
   endtask

   task automatic test_first_retire();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) drive(1'b0, 32'h00001234, 32'h00000013);
         else drive(1'b1, 32'h00001000, 32'd0);
         step();
         for (int m = 0; m < 2; m++) begin
            total++; if (d_state[m] !== 2'd0 || d_ov[m] !== 1'b0) begin bad++; $display("FAIL bubble_idle m=%0d got=%0d/%b exp=0/0", m, d_state[m], d_ov[m]); end
         end
      end
      drive(1'b1, 32'h00400000, 32'h20010001);
      #1;
      total++; if (d_ov[0] !== 1'b0) begin bad++; $display("FAIL first_ov_early got=%b exp=0", d_ov[0]); end
      step();
      for (int m = 0; m < 2; m++) begin
         total++; if (d_state[m] !== 2'd1) begin bad++; $display("FAIL first_state m=%0d got=%0d exp=1", m, d_state[m]); end
         total++; if (d_ov[m] !== 1'b1 || d_pc[m] !== 32'h00400000 || d_instr[m] !== 32'h20010001) begin
            bad++; $display("FAIL first_head m=%0d got=%b %h %h exp=1 00400000 20010001", m, d_ov[m], d_pc[m], d_instr[m]); end
         total++; if (d_rc[m] !== 32'd1) begin bad++; $display("FAIL first_rc m=%0d got=%0d exp=1", m, d_rc[m]); end
      end
      idle_inputs();
      step();
      total++; if (d_ov[0] !== 1'b0 || d_state[0] !== 2'd1) begin bad++; $display("FAIL first_pop got=%b/%0d exp=0/1", d_ov[0], d_state[0]); end
   endtask

   task automatic test_drop();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'h100 + 32'(i * 4), 32'h1000 + 32'(i));
         step();
      end
      idle_inputs();
      total++; if (d_dc[0] !== 16'd2 || d_rc[0] !== 32'd6) begin bad++; $display("FAIL drop_counts got=%0d/%0d exp=2/6", d_dc[0], d_rc[0]); end
      total++; if (d_rc[1] !== 32'd4 || d_dc[1] !== 16'd0) begin bad++; $display("FAIL drop_bp_counts got=%0d/%0d exp=4/0", d_rc[1], d_dc[1]); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int m = 0; m < 2; m++) begin
            total++; if (d_ov[m] !== 1'b1 || d_pc[m] !== 32'h100 + 32'(i * 4) || dhead(m) !== mf[m][0]) begin
               bad++; $display("FAIL drop_order m=%0d i=%0d got=%h exp=%h", m, i, d_pc[m], 32'h100 + 32'(i * 4)); end
         end
         step();
      end
      total++; if (d_ov[0] !== 1'b0 || d_ov[1] !== 1'b0) begin bad++; $display("FAIL drop_empty got=%b%b exp=00", d_ov[0], d_ov[1]); end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h200 + 32'(i * 4), 32'h2000 + 32'(i));
         step();
      end
      drive(1'b1, 32'h210, 32'h2004);
      #1;
      total++; if (d_stall[1] !== 1'b1 || d_stall[0] !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b%b exp=10", d_stall[1], d_stall[0]); end
      step();
      out_ready = 1'b1;
      #1;
      total++; if (d_stall[1] !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", d_stall[1]); end
      step();
      idle_inputs();
      total++; if (d_rc[1] !== 32'd5 || d_dc[1] !== 16'd0 || d_ov[1] !== 1'b1) begin
         bad++; $display("FAIL bp_accept got=%0d/%0d/%b exp=5/0/1", d_rc[1], d_dc[1], d_ov[1]); end
      total++; if (d_rc[0] !== mrc[0] || d_dc[0] !== 16'(mdc[0])) begin bad++; $display("FAIL bp_dropmode got=%0d/%0d exp=%0d/%0d", d_rc[0], d_dc[0], mrc[0], mdc[0]); end
      for (int i = 1; i < 5; i++) begin
         total++; if (d_pc[1] !== 32'h200 + 32'(i * 4)) begin bad++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, d_pc[1], 32'h200 + 32'(i * 4)); end
         step();
      end
   endtask

   task automatic test_halt();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(i * 4), 32'h3000 + 32'(i));
         step();
      end
      drive(1'b1, 32'h30c, 32'h0000000d);
      step();
      for (int m = 0; m < 2; m++) begin
         total++; if (d_state[m] !== 2'd2 || d_rc[m] !== 32'd4) begin bad++; $display("FAIL halt_drain m=%0d got=%0d/%0d exp=2/4", m, d_state[m], d_rc[m]); end
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h310, 32'h3010);
         step();
         total++; if (d_rc[0] !== 32'd4 || d_state[0] !== 2'd2 || d_stall[1] !== 1'b0) begin
            bad++; $display("FAIL halt_ignore got=%0d/%0d/%b exp=4/2/0", d_rc[0], d_state[0], d_stall[1]); end
      end
      idle_inputs();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++; if (d_pc[0] !== 32'h300 + 32'(k * 4)) begin bad++; $display("FAIL halt_order k=%0d got=%h exp=%h", k, d_pc[0], 32'h300 + 32'(k * 4)); end
         step();
         total++; if (d_state[0] !== 2'd2 || d_done[0] !== 1'b0) begin bad++; $display("FAIL halt_early_done k=%0d got=%0d/%b exp=2/0", k, d_state[0], d_done[0]); end
      end
      step();
      for (int m = 0; m < 2; m++) begin
         total++; if (d_state[m] !== 2'd3 || d_done[m] !== 1'b1) begin bad++; $display("FAIL halt_done m=%0d got=%0d/%b exp=3/1", m, d_state[m], d_done[m]); end
      end
   endtask

   task automatic test_max_retire();
      bit reached;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, 32'h400 + 32'(i * 4), $urandom | 32'h100);
         out_ready = 1'(i & 1);
         step();
         total++; if (d_rc[0] !== mrc[0] || d_state[0] !== 2'(mst[0]) || d_ov[0] !== (mcnt[0] > 0)) begin
            bad++; $display("FAIL max_track i=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, d_rc[0], d_state[0], d_ov[0], mrc[0], mst[0], mcnt[0] > 0); end
         if (mcnt[0] > 0) begin
            total++; if (dhead(0) !== mf[0][0]) begin bad++; $display("FAIL max_head i=%0d got=%h exp=%h", i, dhead(0), mf[0][0]); end
         end
      end
      idle_inputs();
      total++; if (d_rc[0] !== 32'd10) begin bad++; $display("FAIL max_limit got=%0d exp=10", d_rc[0]); end
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         out_ready = 1'(i & 1);
         step();
         if (d_state[0] == 2'd3) reached = 1'b1;
      end
      total++; if (!reached || d_rc[0] !== 32'd10) begin bad++; $display("FAIL max_done got=%0d/%0d exp=3/10", d_state[0], d_rc[0]); end
   endtask

   task automatic test_random();
      int k;
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int c = 0; c < 60; c++) begin
            k = $urandom_range(0, 19);
            drive(1'($urandom_range(0, 3) != 0), $urandom,
                  (k < 4) ? 32'd0 : (k == 4) ? 32'h0000000d : ($urandom | 32'h100));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            for (int m = 0; m < 2; m++) begin
               total++; if (d_stall[m] !== mstall(m)) begin bad++; $display("FAIL rnd_stall m=%0d c=%0d got=%b exp=%b", m, c, d_stall[m], mstall(m)); end
            end
            step();
            for (int m = 0; m < 2; m++) begin
               total++; if (d_state[m] !== 2'(mst[m]) || d_done[m] !== (mst[m] == 3)) begin
                  bad++; $display("FAIL rnd_state m=%0d c=%0d got=%0d/%b exp=%0d", m, c, d_state[m], d_done[m], mst[m]); end
               total++; if (d_ov[m] !== (mcnt[m] > 0)) begin bad++; $display("FAIL rnd_ov m=%0d c=%0d got=%b exp=%b", m, c, d_ov[m], mcnt[m] > 0); end
               total++; if (d_rc[m] !== mrc[m] || d_dc[m] !== 16'(mdc[m])) begin
                  bad++; $display("FAIL rnd_cnt m=%0d c=%0d got=%0d/%0d exp=%0d/%0d", m, c, d_rc[m], d_dc[m], mrc[m], mdc[m]); end
               if (mcnt[m] > 0) begin
                  total++; if (dhead(m) !== mf[m][0]) begin bad++; $display("FAIL rnd_head m=%0d c=%0d got=%h exp=%h", m, c, dhead(m), mf[m][0]); end
               end
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1'b1, 32'h500, 32'h5000);
      step();
      drive(1'b1, 32'h504, 32'h5004);
      step();
      idle_inputs();
      total++; if (d_ov[0] !== 1'b1 || d_state[0] !== 2'd1) begin bad++; $display("FAIL ar_pre got=%b/%0d exp=1/1", d_ov[0], d_state[0]); end
      #2;
      rst = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         total++; if (d_ov[m] !== 1'b0 || d_state[m] !== 2'd0 || d_rc[m] !== 32'd0) begin
            bad++; $display("FAIL ar_immediate m=%0d got=%b/%0d/%0d exp=0/0/0", m, d_ov[m], d_state[m], d_rc[m]); end
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      step();
      total++; if (d_ov[0] !== 1'b0 || d_state[0] !== 2'd0) begin bad++; $display("FAIL ar_idle got=%b/%0d exp=0/0", d_ov[0], d_state[0]); end
      drive(1'b1, 32'h600, 32'h6000);
      step();
      idle_inputs();
      total++; if (d_state[0] !== 2'd1 || d_pc[0] !== 32'h600 || d_rc[0] !== 32'd1) begin
         bad++; $display("FAIL ar_restart got=%0d/%h/%0d exp=1/00000600/1", d_state[0], d_pc[0], d_rc[0]); end
   endtask

   initial begin
      rst       = 1'b0;
      out_ready = 1'b0;
      idle_inputs();
      model_reset();
      test_reset();
      test_first_retire();
      test_drop();
      test_backpressure();
      test_halt();
      test_max_retire();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entry count; power of two, 2..256.
REQ-002 Parameter XLEN, default 32, width of pc, instr and write data.
REQ-003 Parameter HALT_INSTR, default 32'h0000000d, the instruction word that ends capture.
REQ-004 Parameter MAX_RETIRE, default 7000, retired-instruction limit that ends capture; 0 means no limit.
REQ-005 Parameter FULL_MODE, default 0; 0 = drop on full, 1 = backpressure on full.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 wb_valid  in  1  a writeback-stage instruction is present this cycle.
REQ-009 wb_pc  in  XLEN  pc of the writeback instruction.
REQ-010 wb_instr  in  XLEN  instruction word; 0 is a bubble.
REQ-011 wb_we, wb_waddr[4:0], wb_wdata[XLEN]  in  register-write enable, index and data.
REQ-012 trace_stall  out  1  backpressure to the pipeline; in FULL_MODE=0 it is held at 0.
REQ-013 out_valid  out  1; out_ready  in  1  drain handshake.
REQ-014 out_pc, out_instr  out  XLEN; out_we  out  1; out_waddr  out  5; out_wdata  out  XLEN  head entry.
REQ-015 retire_cnt  out  32  retired non-bubble instruction count.
REQ-016 drop_cnt  out  16  dropped-entry count; saturates at 16'hFFFF.
REQ-017 state  out  2  current FSM state; done  out  1  high only in DONE.

Function
REQ-018 Retire event: wb_valid=1, wb_instr!=0, and not (FULL_MODE=1 and trace_stall=1).
REQ-019 FSM states: IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
REQ-020 IDLE -> CAPTURE on the first retire event; that event is pushed and counted.
REQ-021 In CAPTURE, each retire event pushes one entry {pc, instr, we, waddr, wdata} and increments retire_cnt by 1.
REQ-022 A retire event with wb_instr==HALT_INSTR is pushed and counted, then the FSM moves CAPTURE -> DRAIN.
REQ-023 When retire_cnt reaches MAX_RETIRE (MAX_RETIRE != 0), the FSM moves CAPTURE -> DRAIN in the same edge.
REQ-024 In DRAIN and DONE, retire events are ignored: no push, no count.
REQ-025 DRAIN -> DONE when the FIFO is empty; DONE holds until reset.
REQ-026 Pop occurs when out_valid=1 and out_ready=1. out_valid = FIFO non-empty. Outputs show the head entry combinationally from storage.
REQ-027 Pointers are log2(DEPTH) bits plus one wrap bit. Empty: pointers equal. Full: indices equal and wrap bits differ. Pointers wrap modulo DEPTH.
REQ-028 A simultaneous push and pop when full is accepted: count stays DEPTH and no drop occurs.
REQ-029 A simultaneous push and pop when empty: the pop is not granted (out_valid=0), the push succeeds, and count becomes 1.
REQ-030 FULL_MODE=0: a push to a full FIFO with no pop is discarded, drop_cnt increments (saturating), and retire_cnt still increments.
REQ-031 FULL_MODE=1: trace_stall = full and no pop this cycle, in state CAPTURE; stalled instructions are not retire events.
REQ-032 retire_cnt is 32-bit and wraps modulo 2^32.

Reset
REQ-033 When rst=0, asynchronously: state=IDLE, pointers=0, retire_cnt=0, drop_cnt=0, out_valid=0, trace_stall=0, done=0.
REQ-034 FIFO storage is not reset; out_pc, out_instr, out_we, out_waddr and out_wdata are don't-care while out_valid=0.
REQ-035 Reset asserted mid-capture or mid-drain discards all entries; after release the FSM waits in IDLE for a new first retire event.

Verification
REQ-036 Bubbles then valid 0x00400000/0x20010001 with out_ready=1 -> IDLE through bubbles; CAPTURE; out_valid one cycle later; retire_cnt=1.
REQ-037 DEPTH=4, FULL_MODE=0, out_ready=0, 6 retires -> 4 entries held, drop_cnt=2, retire_cnt=6; draining returns the first 4 in order.
REQ-038 DEPTH=4, FULL_MODE=1, out_ready=0, 5 retires offered -> trace_stall=1 after the 4th; out_ready=1 for one cycle accepts the 5th; drop_cnt=0.
REQ-039 Retire of 0x0000000d with 3 entries queued -> DRAIN; later retires ignored; DONE exactly on the edge after the 4th pop.
REQ-040 MAX_RETIRE=10, continuous retires -> retire_cnt stops at 10; DRAIN then DONE; DEPTH wrap exercised with out_ready toggling 1/0.
REQ-041 rst pulsed low mid-CAPTURE with 2 entries queued -> out_valid=0 and state=0 immediately, without waiting for a clock edge.
